// File: rtl/multicycle_controller.sv
// Moore control sequencer for the multi-cycle 32-bit MIPS datapath: decodes op/funct, drives mux selects, write strobes and ALU control.
// Latency: outputs are a combinational decode of the current state (pcen also follows zero in the same cycle); one state per clock.
// Backpressure: none; the sequencer advances every cycle, and a synchronous reset returns it to FETCH.
//
// Ports: clk/reset (sync, active-high); op/funct from the IR; zero from the ALU;
//        iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, alusrcb[1:0],
//        pcsrc[1:0], alucontrol[2:0], pcen, state[3:0] (debug).
// Optional feature: define MULTICYCLE_BNE_EN to add the BNEEX state (op 000101).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [3:0] S_BNEEX   = 4'd12;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    logic [3:0] state_q, state_d;
    logic [3:0] cur_state;   // state as seen by the output decode
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       br_cond;
    logic       irwrite_raw, memwrite_raw, regwrite_raw;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;  // unknown op retires as a NOP
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;  // write-back/exec-final states and unused codes
        endcase
    end

    // While reset is held the outputs already look like FETCH, so the
    // datapath sees a clean first cycle the moment reset drops.
    assign cur_state = reset ? S_FETCH : state_q;

    // Output decode
    always_comb begin
        iord         = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        br_cond      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                br_cond = zero;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                br_cond = ~zero;
            end
`endif
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; unknown R-type funct falls back to add
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign irwrite  = irwrite_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = (pcwrite | (branch & br_cond)) & ~reset;
    assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its state sequence.
// Inputs change on the falling edge; outputs are sampled 1ns after the falling edge.
// No backpressure; a watchdog bounds the run.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .state      (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to the sampling point of the next cycle
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // FETCH cycle checks, sampled in the current cycle
    task automatic chk_fetch(input string tag);
        check_eq({tag, " st"}, 32'(state), 32'd0);
        check_eq({tag, " irwrite"}, 32'(irwrite), 32'd1);
        check_eq({tag, " pcen"}, 32'(pcen), 32'd1);
        check_eq({tag, " alusrcb"}, 32'(alusrcb), 32'd1);
    endtask

    task automatic chk_decode(input string tag);
        tick();
        check_eq({tag, " st"}, 32'(state), 32'd1);
        check_eq({tag, " alusrcb"}, 32'(alusrcb), 32'd3);
        check_eq({tag, " pcen"}, 32'(pcen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        tick(); tick();
        // reset state
        check_eq("rst st", 32'(state), 32'd0);
        check_eq("rst irwrite", 32'(irwrite), 32'd0);
        check_eq("rst pcen", 32'(pcen), 32'd0);
        check_eq("rst alusrcb", 32'(alusrcb), 32'd1);
        check_eq("rst aluctl", 32'(alucontrol), 32'b010);
        check_eq("rst regwrite", 32'(regwrite), 32'd0);

        // lw: 0,1,2,3,4,0
        @(negedge clk); reset = 1'b0; op = 6'b100011; #1;
        chk_fetch("lw");
        chk_decode("lw");
        tick(); check_eq("lw s2", 32'(state), 32'd2);
        check_eq("lw s2 srca", 32'(alusrca), 32'd1);
        check_eq("lw s2 srcb", 32'(alusrcb), 32'd2);
        tick(); check_eq("lw s3", 32'(state), 32'd3);
        check_eq("lw s3 iord", 32'(iord), 32'd1);
        tick(); check_eq("lw s4", 32'(state), 32'd4);
        check_eq("lw s4 regwrite", 32'(regwrite), 32'd1);
        check_eq("lw s4 memtoreg", 32'(memtoreg), 32'd1);
        tick();

        // sw: 0,1,2,5,0
        op = 6'b101011;
        chk_fetch("sw");
        chk_decode("sw");
        tick(); check_eq("sw s2", 32'(state), 32'd2);
        check_eq("sw s2 memwrite", 32'(memwrite), 32'd0);
        tick(); check_eq("sw s5", 32'(state), 32'd5);
        check_eq("sw s5 memwrite", 32'(memwrite), 32'd1);
        check_eq("sw s5 iord", 32'(iord), 32'd1);
        check_eq("sw s5 regwrite", 32'(regwrite), 32'd0);
        tick();

        // R-type: slt, and, unknown funct
        op = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            logic [5:0] fv [3];
            logic [2:0] ev [3];
            fv[0] = 6'b101010; ev[0] = 3'b111;
            fv[1] = 6'b100100; ev[1] = 3'b000;
            fv[2] = 6'b111111; ev[2] = 3'b010;
            funct = fv[k];
            chk_fetch("rtype");
            chk_decode("rtype");
            tick(); check_eq("rtype s6", 32'(state), 32'd6);
            check_eq("rtype aluctl", 32'(alucontrol), 32'(ev[k]));
            check_eq("rtype srca", 32'(alusrca), 32'd1);
            check_eq("rtype srcb", 32'(alusrcb), 32'd0);
            tick(); check_eq("rtype s7", 32'(state), 32'd7);
            check_eq("rtype regdst", 32'(regdst), 32'd1);
            check_eq("rtype regwrite", 32'(regwrite), 32'd1);
            tick();
        end

        // beq taken / not taken
        op = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            chk_fetch("beq");
            chk_decode("beq");
            tick(); check_eq("beq s8", 32'(state), 32'd8);
            check_eq("beq pcen", 32'(pcen), (k == 0) ? 32'd1 : 32'd0);
            check_eq("beq pcsrc", 32'(pcsrc), 32'd1);
            check_eq("beq aluctl", 32'(alucontrol), 32'b110);
            tick();
        end
        zero = 1'b0;

        // j
        op = 6'b000010;
        chk_fetch("j");
        chk_decode("j");
        tick(); check_eq("j s11", 32'(state), 32'd11);
        check_eq("j pcsrc", 32'(pcsrc), 32'd2);
        check_eq("j pcen", 32'(pcen), 32'd1);
        tick();

        // addi: 0,1,9,10,0
        op = 6'b001000;
        chk_fetch("addi");
        chk_decode("addi");
        tick(); check_eq("addi s9", 32'(state), 32'd9);
        check_eq("addi srcb", 32'(alusrcb), 32'd2);
        tick(); check_eq("addi s10", 32'(state), 32'd10);
        check_eq("addi regwrite", 32'(regwrite), 32'd1);
        check_eq("addi regdst", 32'(regdst), 32'd0);
        tick();

        // bne (op 000101)
        op = 6'b000101; zero = 1'b0;
        chk_fetch("bne");
        chk_decode("bne");
        check_eq("bne dec regwrite", 32'(regwrite), 32'd0);
        tick();
`ifdef MULTICYCLE_BNE_EN
        check_eq("bne s12", 32'(state), 32'd12);
        check_eq("bne pcen", 32'(pcen), 32'd1);
        check_eq("bne pcsrc", 32'(pcsrc), 32'd1);
        tick();
`else
        check_eq("bne nop st", 32'(state), 32'd0);
`endif
        check_eq("bne back st", 32'(state), 32'd0);

        // reset asserted in MEMWR
        op = 6'b101011;
        tick(); tick(); tick();
        check_eq("rmid s5", 32'(state), 32'd5);
        check_eq("rmid s5 memwrite", 32'(memwrite), 32'd1);
        reset = 1'b1; #1;
        check_eq("rmid memwrite", 32'(memwrite), 32'd0);
        check_eq("rmid st", 32'(state), 32'd0);
        check_eq("rmid srcb", 32'(alusrcb), 32'd1);
        check_eq("rmid pcen", 32'(pcen), 32'd0);
        tick();
        check_eq("rmid held st", 32'(state), 32'd0);
        check_eq("rmid held irwrite", 32'(irwrite), 32'd0);
        @(negedge clk); reset = 1'b0; op = 6'b100011; #1;
        chk_fetch("resume");
        chk_decode("resume");
        tick(); check_eq("resume s2", 32'(state), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
